// File: rtl/aes128_sched.sv
// Two-requester scheduler in front of a shared, pipelined AES-128 core.
// Round-robin issue under a credit limit; results return in order to the issuing requester.
module aes128_sched #(
    parameter int DATA_W     = 128,
    parameter int KEY_L      = 128,
    parameter int OBUF_DEPTH = 16,
    parameter int CNT_W      = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [KEY_L-1:0]  req0_key,
    input  logic [DATA_W-1:0] req0_text,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [KEY_L-1:0]  req1_key,
    input  logic [DATA_W-1:0] req1_text,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_text,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_text,
    output logic              core_data_valid,
    output logic              core_key_valid,
    output logic [KEY_L-1:0]  core_key,
    output logic [DATA_W-1:0] core_text,
    input  logic              core_valid_out,
    input  logic [DATA_W-1:0] core_cipher,
    output logic              busy
);

    // Handshakes: a transfer happens on any cycle where valid && ready; ready never depends on data.
    localparam int PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int SUM_W = CNT_W + 1;

    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  obuf_count;
    logic              rr_ptr;
    logic              issued_since_reset;

    logic              tag_mem [OBUF_DEPTH];
    logic [PTR_W-1:0]  tag_wr_ptr;
    logic [PTR_W-1:0]  tag_rd_ptr;

    logic [DATA_W-1:0] obuf_data [OBUF_DEPTH];
    logic              obuf_tag  [OBUF_DEPTH];
    logic [PTR_W-1:0]  obuf_wr_ptr;
    logic [PTR_W-1:0]  obuf_rd_ptr;

    logic [SUM_W-1:0]  credit_used;
    logic              can_issue;
    logic              grant0;
    logic              grant1;
    logic              issue;
    logic              retire;
    logic              obuf_rd;
    logic              obuf_nonempty;
    logic              head_tag;
    logic [DATA_W-1:0] head_data;

    always_comb begin
        credit_used   = SUM_W'(inflight) + SUM_W'(obuf_count);
        can_issue     = !reset && (credit_used < SUM_W'(OBUF_DEPTH));
        grant0        = can_issue && req0_valid && (!req1_valid || !rr_ptr);
        grant1        = can_issue && req1_valid && (!req0_valid || rr_ptr);
        issue         = grant0 || grant1;
        // The tag FIFO holds exactly one entry per in-flight block, so inflight doubles as its count.
        retire        = core_valid_out && (inflight != '0);
        obuf_nonempty = (obuf_count != '0);
        head_tag      = obuf_tag[obuf_rd_ptr];
        head_data     = obuf_data[obuf_rd_ptr];
        rsp0_valid    = obuf_nonempty && !head_tag;
        rsp1_valid    = obuf_nonempty && head_tag;
        rsp0_text     = rsp0_valid ? head_data : '0;
        rsp1_text     = rsp1_valid ? head_data : '0;
        obuf_rd       = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
        busy          = (inflight != '0) || obuf_nonempty;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr             <= 1'b0;
            issued_since_reset <= 1'b0;
            core_data_valid    <= 1'b0;
            core_key_valid     <= 1'b0;
            core_key           <= '0;
            core_text          <= '0;
            inflight           <= '0;
            obuf_count         <= '0;
            tag_wr_ptr         <= '0;
            tag_rd_ptr         <= '0;
            obuf_wr_ptr        <= '0;
            obuf_rd_ptr        <= '0;
        end else begin
            if (can_issue && req0_valid && req1_valid) begin
                rr_ptr <= !rr_ptr;
            end
            issued_since_reset <= issued_since_reset || issue;

            core_data_valid <= issue;
            core_key_valid  <= issue;
            if (issue) begin
                core_key   <= grant1 ? req1_key  : req0_key;
                core_text  <= grant1 ? req1_text : req0_text;
                tag_wr_ptr <= tag_wr_ptr + PTR_W'(1);
            end

            if (retire) begin
                tag_rd_ptr  <= tag_rd_ptr + PTR_W'(1);
                obuf_wr_ptr <= obuf_wr_ptr + PTR_W'(1);
            end
            if (obuf_rd) begin
                obuf_rd_ptr <= obuf_rd_ptr + PTR_W'(1);
            end

            case ({issue, retire})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase

            case ({retire, obuf_rd})
                2'b10:   obuf_count <= obuf_count + CNT_W'(1);
                2'b01:   obuf_count <= obuf_count - CNT_W'(1);
                default: obuf_count <= obuf_count;
            endcase

            // Stale results right after reset are dropped quietly; only a stray result once traffic
            // has restarted indicates a broken core.
            if (core_valid_out && (inflight == '0)) begin
                assert (!issued_since_reset)
                    else $error("aes128_sched: core result with no block in flight");
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            tag_mem[tag_wr_ptr] <= grant1;
        end
        if (retire) begin
            obuf_data[obuf_wr_ptr] <= core_cipher;
            obuf_tag[obuf_wr_ptr]  <= tag_mem[tag_rd_ptr];
        end
    end

endmodule

// File: tb/tb_aes128_sched.sv
// Directed bench for aes128_sched with a fixed-latency core model that knows the FIPS-197 vector.
module tb_aes128_sched;

    localparam int DATA_W = 128;
    localparam int KEY_L  = 128;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 5;
    localparam int LAT    = 6;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K0       = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] K1       = 128'h99999999_88888888_77777777_66666666;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0_valid, req0_ready, req1_valid, req1_ready;
    logic [KEY_L-1:0]  req0_key, req1_key;
    logic [DATA_W-1:0] req0_text, req1_text;
    logic              rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [DATA_W-1:0] rsp0_text, rsp1_text;
    logic              core_data_valid, core_key_valid;
    logic [KEY_L-1:0]  core_key;
    logic [DATA_W-1:0] core_text;
    logic              core_valid_out;
    logic [DATA_W-1:0] core_cipher;
    logic              busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [127:0] exp_q[$];
    int           exp_port_q[$];
    logic [127:0] got_text_q[$];
    int           got_port_q[$];
    int           n_core_pulses = 0;
    logic         rsp1_any = 1'b0;

    always #5 clk = ~clk;

    aes128_sched #(
        .DATA_W(DATA_W), .KEY_L(KEY_L), .OBUF_DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_key(req0_key), .req0_text(req0_text),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_key(req1_key), .req1_text(req1_text),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_text(rsp0_text),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_text(rsp1_text),
        .core_data_valid(core_data_valid), .core_key_valid(core_key_valid),
        .core_key(core_key), .core_text(core_text),
        .core_valid_out(core_valid_out), .core_cipher(core_cipher),
        .busy(busy)
    );

    // Stand-in cipher: exact for the FIPS-197 vector, an invertible mix for anything else.
    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] t);
        if (k == FIPS_KEY && t == FIPS_PT) return FIPS_CT;
        return t ^ {k[63:0], k[127:64]} ^ 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;
    endfunction

    // Core model: fixed latency, no reset, so blocks in its pipe keep emerging across a DUT reset.
    logic [LAT-1:0]    pipe_v = '0;
    logic [DATA_W-1:0] pipe_d [LAT];
    always @(posedge clk) begin
        pipe_v    <= {pipe_v[LAT-2:0], core_data_valid & core_key_valid};
        pipe_d[0] <= core_fn(core_key, core_text);
        for (int i = 1; i < LAT; i++) pipe_d[i] <= pipe_d[i-1];
    end
    assign core_valid_out = pipe_v[LAT-1];
    assign core_cipher    = pipe_d[LAT-1];

    always @(negedge clk) begin
        if (rsp0_valid && rsp0_ready) begin
            got_port_q.push_back(0);
            got_text_q.push_back(rsp0_text);
        end
        if (rsp1_valid && rsp1_ready) begin
            got_port_q.push_back(1);
            got_text_q.push_back(rsp1_text);
        end
        if (rsp1_valid) rsp1_any = 1'b1;
        if (core_valid_out) n_core_pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp(input int n, input int budget, input string tag);
        int cyc = 0;
        while (got_port_q.size() < n && cyc < budget) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check(tag, 128'(got_port_q.size()), 128'(n));
    endtask

    task automatic expect_rsp(input string tag);
        int           ep;
        logic [127:0] et;
        ep = exp_port_q.pop_front();
        et = exp_q.pop_front();
        if (got_port_q.size() == 0) begin
            n_checks++;
            $error("FAIL %s observed=none expected=%0h", tag, et);
        end else begin
            check({tag, "_port"}, 128'(got_port_q.pop_front()), 128'(ep));
            check({tag, "_text"}, got_text_q.pop_front(), et);
        end
    endtask

    task automatic push_exp(input int port, input logic [127:0] text);
        exp_port_q.push_back(port);
        exp_q.push_back(text);
    endtask

    task automatic clear_q();
        exp_q.delete();
        exp_port_q.delete();
        got_text_q.delete();
        got_port_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           i0, i1, n_iss, pulses_before;
        logic         flag_a, flag_b;
        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_key = '0; req1_key = '0; req0_text = '0; req1_text = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (3) tick();

        // Reset state
        check("reset_req0_ready", 128'(req0_ready), 128'(0));
        check("reset_core_dv", 128'(core_data_valid), 128'(0));
        check("reset_core_kv", 128'(core_key_valid), 128'(0));
        check("reset_core_key", core_key, 128'(0));
        check("reset_rsp0_valid", 128'(rsp0_valid), 128'(0));
        check("reset_rsp1_valid", 128'(rsp1_valid), 128'(0));
        check("reset_rsp0_text", rsp0_text, 128'(0));
        check("reset_busy", 128'(busy), 128'(0));
        req0_valid = 1'b0;
        reset = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        tick();

        // Single FIPS block on requester 0
        clear_q();
        rsp1_any = 1'b0;
        req0_key = FIPS_KEY; req0_text = FIPS_PT; req0_valid = 1'b1;
        #1;
        check("t1_req0_ready", 128'(req0_ready), 128'(1));
        check("t1_req1_ready", 128'(req1_ready), 128'(0));
        push_exp(0, FIPS_CT);
        tick();
        req0_valid = 1'b0;
        check("t1_core_dv", 128'(core_data_valid), 128'(1));
        check("t1_core_kv", 128'(core_key_valid), 128'(1));
        check("t1_core_key", core_key, FIPS_KEY);
        check("t1_core_text", core_text, FIPS_PT);
        check("t1_busy", 128'(busy), 128'(1));
        tick();
        check("t1_core_dv_drop", 128'(core_data_valid), 128'(0));
        check("t1_core_key_hold", core_key, FIPS_KEY);
        wait_rsp(1, 30, "t1_wait");
        tick();
        check("t1_busy_clear", 128'(busy), 128'(0));
        expect_rsp("t1_rsp");
        check("t1_rsp1_quiet", 128'(rsp1_any), 128'(0));

        // Both requesters for 8 cycles: strict alternation starting with requester 0
        clear_q();
        req0_key = K0; req1_key = K1;
        i0 = 0; i1 = 0;
        for (int c = 0; c < 8; c++) begin
            req0_text = 128'hA000 + 128'(i0);
            req1_text = 128'hB000 + 128'(i1);
            req0_valid = 1'b1; req1_valid = 1'b1;
            #1;
            check("t2_grant0", 128'(req0_ready), 128'((c % 2) == 0));
            check("t2_grant1", 128'(req1_ready), 128'((c % 2) == 1));
            if ((c % 2) == 0) begin
                push_exp(0, core_fn(K0, req0_text));
                i0++;
            end else begin
                push_exp(1, core_fn(K1, req1_text));
                i1++;
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(8, 40, "t2_wait");
        for (int c = 0; c < 8; c++) expect_rsp("t2_rsp");
        tick();

        // Credit limit: requester 0 streams with its response path stalled
        clear_q();
        rsp0_ready = 1'b0;
        n_iss = 0;
        for (int c = 0; c < 40; c++) begin
            req0_text = 128'hC000 + 128'(n_iss);
            req0_valid = 1'b1;
            #1;
            if (req0_ready) begin
                push_exp(0, core_fn(K0, req0_text));
                n_iss++;
            end
            tick();
        end
        check("t3_issued", 128'(n_iss), 128'(DEPTH));
        check("t3_ready_low", 128'(req0_ready), 128'(0));
        check("t3_busy", 128'(busy), 128'(1));
        check("t3_head_valid", 128'(rsp0_valid), 128'(1));
        check("t3_head_text", rsp0_text, core_fn(K0, 128'hC000));
        req0_valid = 1'b0;
        rsp0_ready = 1'b1;
        wait_rsp(DEPTH, 60, "t3_drain_wait");
        for (int c = 0; c < DEPTH; c++) expect_rsp("t3_drain");
        tick();
        req0_text = 128'hD000; req0_valid = 1'b1;
        #1;
        check("t3_resume", 128'(req0_ready), 128'(1));
        push_exp(0, core_fn(K0, 128'hD000));
        tick();
        req0_valid = 1'b0;
        wait_rsp(1, 30, "t3_resume_wait");
        expect_rsp("t3_resume_rsp");
        tick();

        // Head-of-line blocking: requester 1's stalled result holds back requester 0's
        clear_q();
        rsp1_ready = 1'b0;
        req1_text = 128'hE001; req1_valid = 1'b1;
        #1;
        check("t4_req1_ready", 128'(req1_ready), 128'(1));
        push_exp(1, core_fn(K1, 128'hE001));
        tick();
        req1_valid = 1'b0;
        req0_text = 128'hE000; req0_valid = 1'b1;
        #1;
        check("t4_req0_ready", 128'(req0_ready), 128'(1));
        push_exp(0, core_fn(K0, 128'hE000));
        tick();
        req0_valid = 1'b0;
        flag_a = 1'b0;
        repeat (30) begin
            tick();
            if (rsp0_valid) flag_a = 1'b1;
        end
        check("t4_rsp0_blocked", 128'(flag_a), 128'(0));
        check("t4_rsp1_valid", 128'(rsp1_valid), 128'(1));
        check("t4_rsp1_stable", rsp1_text, core_fn(K1, 128'hE001));
        rsp1_ready = 1'b1;
        wait_rsp(2, 20, "t4_wait");
        expect_rsp("t4_first");
        expect_rsp("t4_second");
        tick();

        // Steady state: one issue per cycle, busy held, busy drops right after the last response
        clear_q();
        flag_a = 1'b0; flag_b = 1'b0;
        for (int c = 0; c < 30; c++) begin
            req0_text = 128'hF000 + 128'(c);
            req0_valid = 1'b1;
            #1;
            if (!req0_ready) flag_a = 1'b1;
            if (c >= 2 && !busy) flag_b = 1'b1;
            push_exp(0, core_fn(K0, req0_text));
            tick();
        end
        req0_valid = 1'b0;
        check("t5_throughput", 128'(flag_a), 128'(0));
        check("t5_busy_held", 128'(flag_b), 128'(0));
        wait_rsp(30, 60, "t5_wait");
        tick();
        check("t5_busy_clear", 128'(busy), 128'(0));
        for (int c = 0; c < 30; c++) expect_rsp("t5_rsp");
        tick();

        // Reset with five blocks in the core; the late results must be discarded
        clear_q();
        for (int c = 0; c < 5; c++) begin
            req0_text = 128'h7000 + 128'(c);
            req0_valid = 1'b1;
            tick();
        end
        req0_valid = 1'b0;
        pulses_before = n_core_pulses;
        reset = 1'b1;
        tick();
        check("t6_core_dv", 128'(core_data_valid), 128'(0));
        check("t6_core_key", core_key, 128'(0));
        check("t6_core_text", core_text, 128'(0));
        check("t6_busy", 128'(busy), 128'(0));
        check("t6_rsp0_valid", 128'(rsp0_valid), 128'(0));
        reset = 1'b0;
        flag_a = 1'b0;
        repeat (12) begin
            tick();
            if (busy || rsp0_valid || rsp1_valid) flag_a = 1'b1;
        end
        check("t6_late_pulses", 128'(n_core_pulses - pulses_before), 128'(5));
        check("t6_dropped", 128'(flag_a), 128'(0));
        check("t6_no_rsp", 128'(got_port_q.size()), 128'(0));
        req1_key = FIPS_KEY; req1_text = FIPS_PT; req1_valid = 1'b1;
        #1;
        check("t6_new_ready", 128'(req1_ready), 128'(1));
        push_exp(1, FIPS_CT);
        tick();
        req1_valid = 1'b0;
        wait_rsp(1, 30, "t6_new_wait");
        tick();
        check("t6_busy_clear", 128'(busy), 128'(0));
        expect_rsp("t6_new_rsp");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
